// File: rtl/ifetch_if.sv
// ifetch_if: bundles the two buses of the fetch stage.
//   Instruction RAM side : ram_addr, ram_enab, ram_rw (fetch -> iram), ram_data (iram -> fetch)
//   Decoder side         : ir, ir_pc, ir_valid (fetch -> decoder), ir_ready (decoder -> fetch)
// Modports:
//   master : the fetch stage
//   slave  : the environment (iram data return plus decoder ready)
// Parameters d_width / a_width must match the values given to ifetch.
interface ifetch_if #(
    parameter int d_width = 16,
    parameter int a_width = 8
);
    logic [a_width-1:0] ram_addr;
    logic               ram_enab;
    logic               ram_rw;
    logic [d_width-1:0] ram_data;
    logic [d_width-1:0] ir;
    logic [a_width-1:0] ir_pc;
    logic               ir_valid;
    logic               ir_ready;

    modport master (
        output ram_addr, ram_enab, ram_rw, ir, ir_pc, ir_valid,
        input  ram_data, ir_ready
    );

    modport slave (
        input  ram_addr, ram_enab, ram_rw, ir, ir_pc, ir_valid,
        output ram_data, ir_ready
    );
endinterface

// File: rtl/ifetch.sv
// ifetch: instruction fetch stage of the accumulator processor.
// Owns the program counter, issues one-cycle reads to the registered-read
// instruction RAM, captures the returned word into the instruction register
// and offers it to the decoder over a valid/ready handshake.
//
// Ports:
//   clk       in   sole clock, rising edge
//   clr       in   synchronous active-low reset
//   run       in   fetch enable (looked at in IDLE and at handshake end)
//   jmp       in   one-cycle redirect strobe
//   jmp_addr  in   redirect target
//   pc        out  next fetch address
//   halted    out  fetch permanently stopped
//   bus       ifetch_if.master (RAM read port + decoder handshake)
//
// Optional feature macro: FETCH_HALT_EN -- a presented word with top nibble
// 4'hF sends the stage to HALT once the decoder takes it. Without the macro
// halted is tied low and such words are ordinary instructions.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | not fetching, RAM disabled, waiting for run
// REQ   | RAM enabled at pc; RAM latches memory[pc] at the edge
// CAP   | RAM word valid; captured into ir at the edge
// HOLD  | ir presented (ir_valid=1) until the decoder accepts it
// HALT  | (FETCH_HALT_EN only) stopped until clr
module ifetch #(
    parameter int d_width  = 16,
    parameter int a_width  = 8,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               run,
    input  logic               jmp,
    input  logic [a_width-1:0] jmp_addr,
    output logic [a_width-1:0] pc,
    output logic               halted,
    ifetch_if.master           bus
);

`ifdef FETCH_HALT_EN
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_CAP, S_HOLD, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_CAP, S_HOLD} state_t;
`endif

    localparam logic [a_width-1:0] PC_RST = RESET_PC[a_width-1:0];

    state_t             state_q, state_d;
    logic [a_width-1:0] pc_q, pc_d;
    logic [d_width-1:0] ir_q, ir_d;
    logic [a_width-1:0] ir_pc_q, ir_pc_d;
    logic               ir_valid_q, ir_valid_d;
`ifdef FETCH_HALT_EN
    logic               halted_q, halted_d;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
`ifdef FETCH_HALT_EN
        halted_d   = halted_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (jmp)      pc_d    = jmp_addr;
                else if (run) state_d = S_REQ;
            end
            S_REQ: begin
                // A redirect squashes this read; the next REQ cycle issues the target.
                if (jmp) pc_d    = jmp_addr;
                else     state_d = S_CAP;
            end
            S_CAP: begin
                if (jmp) begin
                    pc_d    = jmp_addr;
                    state_d = run ? S_REQ : S_IDLE;
                end else begin
                    ir_d       = bus.ram_data;
                    ir_pc_d    = pc_q;
                    pc_d       = pc_q + 1'b1;
                    ir_valid_d = 1'b1;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                // A jump alongside ir_ready wins; the held word counts as consumed.
                if (jmp) begin
                    pc_d       = jmp_addr;
                    ir_valid_d = 1'b0;
                    state_d    = run ? S_REQ : S_IDLE;
                end else if (bus.ir_ready) begin
                    ir_valid_d = 1'b0;
`ifdef FETCH_HALT_EN
                    if (ir_q[d_width-1 -: 4] == 4'hF) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d = run ? S_REQ : S_IDLE;
                    end
`else
                    state_d = run ? S_REQ : S_IDLE;
`endif
                end
            end
`ifdef FETCH_HALT_EN
            S_HALT: begin
                state_d = S_HALT;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q    <= S_IDLE;
            pc_q       <= PC_RST;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
`ifdef FETCH_HALT_EN
            halted_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
`ifdef FETCH_HALT_EN
            halted_q   <= halted_d;
`endif
        end
    end

    assign bus.ram_addr = pc_q;
    assign bus.ram_enab = (state_q == S_REQ);
    assign bus.ram_rw   = 1'b0;
    assign bus.ir       = ir_q;
    assign bus.ir_pc    = ir_pc_q;
    assign bus.ir_valid = ir_valid_q;
    assign pc           = pc_q;
`ifdef FETCH_HALT_EN
    assign halted       = halted_q;
`else
    assign halted       = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed bench for ifetch with a behavioural registered-read iram
// and a scoreboard queue of expected (ir, ir_pc) pairs.
module tb_ifetch;
    logic       clk;
    logic       clr;
    logic       run;
    logic       jmp;
    logic [7:0] jmp_addr;
    logic [7:0] pc;
    logic       halted;

    ifetch_if #(.d_width(16), .a_width(8)) bus ();

    ifetch #(.d_width(16), .a_width(8), .RESET_PC(0)) dut (
        .clk      (clk),
        .clr      (clr),
        .run      (run),
        .jmp      (jmp),
        .jmp_addr (jmp_addr),
        .pc       (pc),
        .halted   (halted),
        .bus      (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // iram model: registered read, 16'h0055 when not enabled
    logic [15:0] mem [256];
    logic [15:0] rd_q;
    logic [7:0]  last_rd_addr;
    always @(posedge clk) begin
        if (bus.ram_enab === 1'b1) begin
            rd_q         <= mem[bus.ram_addr];
            last_rd_addr <= bus.ram_addr;
        end else begin
            rd_q <= 16'h0055;
        end
    end
    assign bus.ram_data = rd_q;

    typedef struct {
        logic [15:0] ir;
        logic [7:0]  pc;
    } exp_t;
    exp_t sbq [$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [15:0] w, input logic [7:0] a);
        exp_t e;
        e.ir = w;
        e.pc = a;
        sbq.push_back(e);
    endtask

    task automatic wait_valid(input int budget, output int waited);
        waited = 0;
        while (bus.ir_valid !== 1'b1 && waited < budget) begin
            tick();
            waited++;
        end
    endtask

    // wait for a presented word, compare it against the scoreboard head,
    // then let one edge pass so the handshake (ir_ready assumed 1) completes
    task automatic take(input string tag, input int budget, output int waited);
        exp_t e;
        wait_valid(budget, waited);
        chk({tag, "_valid"}, {31'b0, bus.ir_valid}, 32'd1);
        chk({tag, "_sbq"}, (sbq.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (bus.ir_valid === 1'b1) begin
                chk({tag, "_ir"}, {16'b0, bus.ir}, {16'b0, e.ir});
                chk({tag, "_ir_pc"}, {24'b0, bus.ir_pc}, {24'b0, e.pc});
            end
        end
        tick();
    endtask

    int w;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h000F;
        mem[8'h01] = 16'h003F;
        mem[8'h02] = 16'h007F;
        mem[8'h03] = 16'hF000;
        mem[8'h04] = 16'h4444;
        mem[8'h80] = 16'h1234;
        mem[8'h81] = 16'h5555;
        mem[8'hFF] = 16'hAAAA;

        clr = 1'b0; run = 1'b0; jmp = 1'b0; jmp_addr = 8'h00;
        bus.ir_ready = 1'b0;
        tick();
        tick();

        // reset state
        chk("rst_ir_valid", {31'b0, bus.ir_valid}, 32'd0);
        chk("rst_ir", {16'b0, bus.ir}, 32'h0);
        chk("rst_ir_pc", {24'b0, bus.ir_pc}, 32'h0);
        chk("rst_pc", {24'b0, pc}, 32'h0);
        chk("rst_enab", {31'b0, bus.ram_enab}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("ram_rw", {31'b0, bus.ram_rw}, 32'd0);

        clr = 1'b1;
        tick();
        chk("idle_enab", {31'b0, bus.ram_enab}, 32'd0);

        // first fetch: run sampled at E0, word valid after E2
        run = 1'b1;
        push(16'h000F, 8'h00);
        tick();
        chk("req_enab", {31'b0, bus.ram_enab}, 32'd1);
        chk("req_addr", {24'b0, bus.ram_addr}, 32'h00);
        tick();
        chk("cap_enab", {31'b0, bus.ram_enab}, 32'd0);
        chk("cap_valid", {31'b0, bus.ir_valid}, 32'd0);
        wait_valid(10, w);
        chk("first_latency", w, 32'd1);

        // backpressure for 5 cycles
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'b0, bus.ir_valid}, 32'd1);
            chk("bp_ir", {16'b0, bus.ir}, 32'h000F);
            chk("bp_enab", {31'b0, bus.ram_enab}, 32'd0);
            chk("bp_pc", {24'b0, pc}, 32'h01);
            tick();
        end

        // release; then steady state at one word per 3 cycles
        bus.ir_ready = 1'b1;
        take("w0", 10, w);
        chk("w0_wait", w, 32'd0);
        push(16'h003F, 8'h01);
        push(16'h007F, 8'h02);
        take("w1", 10, w);
        chk("w1_period", w, 32'd2);
        chk("w1_rd_addr", {24'b0, last_rd_addr}, 32'h01);
        take("w2", 10, w);
        chk("w2_period", w, 32'd2);

        // now in REQ for address 3; jump during CAP to 0x80
        tick();
        jmp = 1'b1; jmp_addr = 8'h80;
        tick();
        jmp = 1'b0;
        chk("jcap_valid", {31'b0, bus.ir_valid}, 32'd0);
        chk("jcap_pc", {24'b0, pc}, 32'h80);
        push(16'h1234, 8'h80);
        take("jcap", 10, w);
        chk("jcap_cost", (w >= 2) ? 32'd1 : 32'd0, 32'd1);

        // in REQ for 0x81: jump squashes the read, wrap 0xFF -> 0x00
        jmp = 1'b1; jmp_addr = 8'hFF;
        tick();
        jmp = 1'b0;
        chk("jreq_pc", {24'b0, pc}, 32'hFF);
        chk("jreq_enab", {31'b0, bus.ram_enab}, 32'd1);
        push(16'hAAAA, 8'hFF);
        push(16'h000F, 8'h00);
        take("wrap0", 10, w);
        take("wrap1", 10, w);
        chk("wrap_pc", {24'b0, pc}, 32'h01);

        // reset mid-fetch (during CAP)
        tick();
        clr = 1'b0; run = 1'b0;
        tick();
        clr = 1'b1;
        chk("mrst_valid", {31'b0, bus.ir_valid}, 32'd0);
        chk("mrst_ir", {16'b0, bus.ir}, 32'h0);
        chk("mrst_pc", {24'b0, pc}, 32'h0);
        chk("mrst_enab", {31'b0, bus.ram_enab}, 32'd0);
        tick();
        chk("mrst_idle", {31'b0, bus.ram_enab}, 32'd0);

        // jump in IDLE to address 3, then fetch the F000 word
        jmp = 1'b1; jmp_addr = 8'h03;
        tick();
        jmp = 1'b0;
        chk("jidle_pc", {24'b0, pc}, 32'h03);
        chk("jidle_enab", {31'b0, bus.ram_enab}, 32'd0);
        run = 1'b1;
        push(16'hF000, 8'h03);
        take("fword", 10, w);
`ifdef FETCH_HALT_EN
        chk("halt_flag", {31'b0, halted}, 32'd1);
        chk("halt_valid", {31'b0, bus.ir_valid}, 32'd0);
        jmp = 1'b1; jmp_addr = 8'h00;
        tick();
        jmp = 1'b0;
        chk("halt_jmp_pc", {24'b0, pc}, 32'h04);
        for (int i = 0; i < 3; i++) begin
            chk("halt_enab", {31'b0, bus.ram_enab}, 32'd0);
            tick();
        end
        chk("halt_hold", {31'b0, halted}, 32'd1);
`else
        chk("nohalt_flag", {31'b0, halted}, 32'd0);
        push(16'h4444, 8'h04);
        take("after_f", 10, w);
        chk("after_f_period", w, 32'd2);
`endif

        clr = 1'b0;
        tick();
        clr = 1'b1;
        chk("end_halted", {31'b0, halted}, 32'd0);
        chk("end_pc", {24'b0, pc}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
